// File: rtl/delay_sweep_ctrl.sv
// delay_sweep_ctrl: steps a pulse-generator delay across a sweep and
// gates digitizer acquisition for a fixed number of periods per step.
module delay_sweep_ctrl #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] del_start,
    input  logic [DW-1:0] del_step,
    input  logic [CW-1:0] n_steps,
    input  logic [CW-1:0] shots,
    input  logic          sync_in,
    output logic [DW-1:0] del_out,
    output logic [CW-1:0] step_idx,
    output logic          busy,
    output logic          acq_en,
    output logic          step_done,
    output logic          done,
    output logic          sat
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACQ,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] del_q, del_d;
    logic [DW-1:0] step_q, step_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] nst_q, nst_d;
    logic [CW-1:0] shots_q, shots_d;
    logic [CW-1:0] shot_q, shot_d;
    logic          acq_q, acq_d;
    logic          sdone_q, sdone_d;
    logic          done_q, done_d;
    logic          sat_q, sat_d;

    logic          s1_q, s2_q, s3_q;
    logic          edge_q, edge_d;

    logic [DW:0]   sum;
    logic [CW-1:0] shot_inc;
    logic          last_shot;
    logic          last_step;

    // edge event: rises one cycle after the synchronized sync_in goes high
    always_comb begin
        edge_d = s2_q & ~s3_q;
    end

    // two-flop synchronizer plus delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= sync_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= edge_d;
        end
    end

    // saturating delay increment and step/shot terminal conditions
    always_comb begin
        sum       = {1'b0, del_q} + {1'b0, step_q};
        shot_inc  = shot_q + CW'(1);
        last_shot = (shot_inc == shots_q);
        last_step = (idx_q == nst_q - CW'(1));
    end

    // sweep sequencer: next state and registered outputs
    always_comb begin
        state_d = state_q;
        del_d   = del_q;
        step_d  = step_q;
        idx_d   = idx_q;
        nst_d   = nst_q;
        shots_d = shots_q;
        shot_d  = shot_q;
        acq_d   = acq_q;
        sat_d   = sat_q;
        sdone_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_steps != '0 && shots != '0) begin
                        step_d  = del_step;
                        nst_d   = n_steps;
                        shots_d = shots;
                        del_d   = del_start;
                        idx_d   = '0;
                        sat_d   = 1'b0;
                        shot_d  = '0;
                        state_d = SETTLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    acq_d   = 1'b0;
                    state_d = IDLE;
                end else if (edge_q) begin
                    shot_d  = '0;
                    acq_d   = 1'b1;
                    state_d = ACQ;
                end
            end
            ACQ: begin
                if (abort) begin
                    acq_d   = 1'b0;
                    state_d = IDLE;
                end else if (edge_q) begin
                    if (last_shot) begin
                        sdone_d = 1'b1;
                        acq_d   = 1'b0;
                        shot_d  = '0;
                        if (last_step) begin
                            state_d = DONE;
                        end else begin
                            if (sum[DW]) begin
                                del_d = '1;
                                sat_d = 1'b1;
                            end else begin
                                del_d = sum[DW-1:0];
                            end
                            idx_d   = idx_q + CW'(1);
                            state_d = SETTLE;
                        end
                    end else begin
                        shot_d = shot_inc;
                    end
                end
            end
            DONE: begin
                acq_d   = 1'b0;
                state_d = IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                acq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // sequencer state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            del_q   <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            nst_q   <= '0;
            shots_q <= '0;
            shot_q  <= '0;
            acq_q   <= 1'b0;
            sdone_q <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            del_q   <= del_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            nst_q   <= nst_d;
            shots_q <= shots_d;
            shot_q  <= shot_d;
            acq_q   <= acq_d;
            sdone_q <= sdone_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign del_out   = del_q;
    assign step_idx  = idx_q;
    assign busy      = (state_q != IDLE);
    assign acq_en    = acq_q;
    assign step_done = sdone_q;
    assign done      = done_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// tb_delay_sweep_ctrl: scoreboard bench for the delay sweep controller.
// Expected steps are derived from sweep arithmetic, not the RTL.
module tb_delay_sweep_ctrl;

    localparam int     DW   = 16;
    localparam int     CW   = 16;
    localparam longint DMAX = (longint'(1) << DW) - 1;

    typedef struct {
        bit     is_done;
        longint del;
        int     idx;
        bit     sat;
        int     shots;
    } rec_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          sync_in   = 1'b0;
    logic [DW-1:0] del_start = '0;
    logic [DW-1:0] del_step  = '0;
    logic [CW-1:0] n_steps   = '0;
    logic [CW-1:0] shots     = '0;
    logic [DW-1:0] del_out;
    logic [CW-1:0] step_idx;
    logic          busy;
    logic          acq_en;
    logic          step_done;
    logic          done;
    logic          sat;

    rec_t   sbq[$];
    rec_t   mon_r;
    longint m_del     = 0;
    bit     m_sat     = 1'b0;
    int     n_chk     = 0;
    int     n_pass    = 0;
    int     sync_per  = 10;
    int     sync_cnt  = 0;
    int     acq_rises = 0;
    int     acq_base  = 0;
    logic   acq_prev  = 1'b0;

    delay_sweep_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .del_start (del_start),
        .del_step  (del_step),
        .n_steps   (n_steps),
        .shots     (shots),
        .sync_in   (sync_in),
        .del_out   (del_out),
        .step_idx  (step_idx),
        .busy      (busy),
        .acq_en    (acq_en),
        .step_done (step_done),
        .done      (done),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    // free-running scope trigger: 3 cycles high every sync_per cycles
    always @(posedge clk) begin
        #1;
        if (sync_cnt == 0) sync_in = 1'b1;
        else if (sync_cnt == 3) sync_in = 1'b0;
        sync_cnt = (sync_cnt + 1 >= sync_per) ? 0 : sync_cnt + 1;
    end

    // trigger periods seen while acquisition is enabled
    always @(posedge sync_in) begin
        if (acq_en) acq_rises = acq_rises + 1;
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: compares DUT events against the scoreboard queue
    always @(negedge clk) begin
        if (reset) begin
            if (acq_en && !acq_prev) begin
                acq_base = acq_rises;
                if (sbq.size() == 0 || sbq[0].is_done) begin
                    check("acq_unexpected", 1, 0);
                end else begin
                    check("step_del", longint'(del_out), sbq[0].del);
                    check("step_idx", longint'(step_idx),
                          longint'(sbq[0].idx));
                    check("step_sat", longint'(sat), longint'(sbq[0].sat));
                    check("acq_busy", longint'(busy), 1);
                end
            end
            if (step_done) begin
                if (sbq.size() == 0 || sbq[0].is_done) begin
                    check("step_done_unexpected", 1, 0);
                end else begin
                    mon_r = sbq.pop_front();
                    check("shot_count", longint'(acq_rises - acq_base),
                          longint'(mon_r.shots));
                    check("acq_off_at_step_done", longint'(acq_en), 0);
                end
            end
            if (done) begin
                if (sbq.size() == 0 || !sbq[0].is_done) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mon_r = sbq.pop_front();
                    check("done_busy", longint'(busy), 0);
                    check("done_del", longint'(del_out), mon_r.del);
                    check("done_sat", longint'(sat), longint'(mon_r.sat));
                end
            end
        end
        acq_prev = acq_en;
    end

    // issue a start; the model only reacts when no sweep is in flight
    task automatic do_start(input longint ds, input longint dst,
                            input int ns, input int sh);
        bit idle;
        bit zero;
        rec_t r;
        longint raw;
        idle = (sbq.size() == 0);
        zero = (ns == 0 || sh == 0);
        del_start = DW'(ds);
        del_step  = DW'(dst);
        n_steps   = CW'(ns);
        shots     = CW'(sh);
        start     = 1'b1;
        if (idle) begin
            if (!zero) begin
                for (int i = 0; i < ns; i++) begin
                    raw       = ds + longint'(i) * dst;
                    r.is_done = 1'b0;
                    r.del     = (raw > DMAX) ? DMAX : raw;
                    r.idx     = i;
                    r.sat     = (raw > DMAX);
                    r.shots   = sh;
                    sbq.push_back(r);
                    m_del = r.del;
                    m_sat = r.sat;
                end
            end
            r.is_done = 1'b1;
            r.del     = m_del;
            r.idx     = 0;
            r.sat     = m_sat;
            r.shots   = 0;
            sbq.push_back(r);
        end
        tick();
        start = 1'b0;
        if (idle && zero) begin
            check("zero_done_latency", longint'(done), 1);
            check("zero_busy", longint'(busy), 0);
        end
        del_start = DW'($urandom);
        del_step  = DW'($urandom);
        n_steps   = CW'($urandom_range(0, 6));
        shots     = CW'($urandom_range(0, 6));
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < budget) begin
            tick();
            k = k + 1;
        end
        check("sweep_finished_in_time", longint'(sbq.size()), 0);
        sbq.delete();
        repeat (3) tick();
    endtask

    task automatic wait_acq(input string name);
        int k;
        k = 0;
        while (!acq_en && k < 300) begin
            tick();
            k = k + 1;
        end
        check(name, longint'(acq_en), 1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_del_out", longint'(del_out), 0);
        check("rst_step_idx", longint'(step_idx), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_acq_en", longint'(acq_en), 0);
        check("rst_step_done", longint'(step_done), 0);
        check("rst_done", longint'(done), 0);
        check("rst_sat", longint'(sat), 0);
        reset = 1'b1;
        repeat (3) tick();

        do_start(200, 50, 3, 4);
        wait_idle(1500);
        check("normal_final_del", longint'(del_out), 300);
        check("normal_final_idx", longint'(step_idx), 2);

        do_start(300, 20, 2, 2);
        do_start(900, 5, 4, 1);
        wait_idle(1500);

        do_start(1234, 1, 3, 0);
        wait_idle(50);
        do_start(4321, 1, 0, 2);
        wait_idle(50);
        check("zero_del_unchanged", longint'(del_out), 320);

        do_start(65500, 100, 2, 1);
        wait_idle(1500);
        check("sat_sticky", longint'(sat), 1);
        check("sat_del", longint'(del_out), 65535);
        do_start(10, 10, 1, 1);
        wait_idle(1500);
        check("sat_cleared", longint'(sat), 0);

        do_start(200, 50, 3, 4);
        wait_acq("abort_reached_acq");
        @(posedge sync_in);
        @(posedge sync_in);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        if (sbq.size() != 0 && !sbq[0].is_done) begin
            m_del = sbq[0].del;
            m_sat = sbq[0].sat;
        end
        sbq.delete();
        check("abort_busy", longint'(busy), 0);
        check("abort_acq_en", longint'(acq_en), 0);
        check("abort_del_hold", longint'(del_out), 200);
        check("abort_idx_hold", longint'(step_idx), 0);
        repeat (40) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_ignored", longint'(busy), 0);

        do_start(1000, 7, 3, 3);
        wait_acq("reset_reached_acq");
        repeat (4) tick();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_del_out", longint'(del_out), 0);
        check("mid_rst_step_idx", longint'(step_idx), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_acq_en", longint'(acq_en), 0);
        check("mid_rst_step_done", longint'(step_done), 0);
        check("mid_rst_done", longint'(done), 0);
        check("mid_rst_sat", longint'(sat), 0);
        sbq.delete();
        m_del = 0;
        m_sat = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) tick();
        do_start(400, 25, 3, 2);
        wait_idle(1500);

        for (int n = 0; n < 14; n++) begin
            longint ds;
            longint dst;
            int ns;
            int sh;
            sync_per = int'($urandom_range(7, 12));
            if ($urandom_range(0, 3) == 0) ds = $urandom_range(60000, 65535);
            else ds = $urandom_range(0, 40000);
            dst = $urandom_range(0, 3000);
            ns  = int'($urandom_range(0, 4));
            sh  = int'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0) sh = 0;
            do_start(ds, dst, ns, sh);
            if (ns != 0 && sh != 0 && $urandom_range(0, 2) == 0) begin
                do_start($urandom_range(0, 65535), 1, 2, 2);
            end
            wait_idle(1500);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
